// File: rtl/wdgrv_wb_master_pkg.sv
// Shared types and watchdog register map for the Wishbone initiator.
// Offsets and WDCSR field positions let callers build watchdog accesses symbolically.
package wdgrv_wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [7:0] WDGRV_WDCSR_OFFSET = 8'h00;
  localparam logic [7:0] WDGRV_WDCNT_OFFSET = 8'h04;

  // WDCSR field layout
  localparam int WDCSR_WDEN_LSB     = 0;
  localparam int WDCSR_WDEN_WIDTH   = 1;
  localparam int WDCSR_S1WTO_LSB    = 2;
  localparam int WDCSR_S1WTO_WIDTH  = 1;
  localparam int WDCSR_S2WTO_LSB    = 3;
  localparam int WDCSR_S2WTO_WIDTH  = 1;
  localparam int WDCSR_WTOCNT_LSB   = 4;
  localparam int WDCSR_WTOCNT_WIDTH = 10;

endpackage

// File: rtl/wdgrv_wb_master.sv
// Single-outstanding Wishbone B4 pipelined initiator: one command in, one bus cycle,
// one response out, with a bus timeout so a hung slave cannot lock the requester.
module wdgrv_wb_master
  import wdgrv_wb_master_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic                      i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]  i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]     i_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_cmd_sel,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [DATA_WIDTH-1:0]     o_rsp_rdata,
  output logic                      o_rsp_err,
  output logic                      o_rsp_timeout,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_we,
  output logic [ADDRESS_WIDTH-1:0]  o_wb_adr,
  output logic [DATA_WIDTH-1:0]     o_wb_dat,
  output logic [DATA_WIDTH/8-1:0]   o_wb_sel,
  input  logic                      i_wb_stall,
  input  logic                      i_wb_ack,
  input  logic                      i_wb_err,
  input  logic [DATA_WIDTH-1:0]     i_wb_dat
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
    TIMEOUT_EN ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  state_e                     state_reg, state_next;
  logic [TIMEOUT_WIDTH-1:0]   cnt_reg;
  logic                       bus_done, bus_timeout;

  logic                       wb_cyc_reg, wb_stb_reg, wb_we_reg;
  logic [ADDRESS_WIDTH-1:0]   wb_adr_reg;
  logic [DATA_WIDTH-1:0]      wb_dat_reg;
  logic [DATA_WIDTH/8-1:0]    wb_sel_reg;
  logic                       rsp_valid_reg, rsp_err_reg, rsp_timeout_reg;
  logic [DATA_WIDTH-1:0]      rsp_rdata_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Ack/err only count once the request has been taken (not stalled) or while waiting.
  always_comb begin
    state_next  = state_reg;
    bus_done    = 1'b0;
    bus_timeout = 1'b0;
    case (state_reg)
      IDLE: if (i_cmd_valid) state_next = REQ;
      REQ, WAIT: begin
        bus_done    = (i_wb_ack || i_wb_err) && ((state_reg == WAIT) || !i_wb_stall);
        bus_timeout = TIMEOUT_EN && !bus_done && (cnt_reg == TIMEOUT_LAST);
        if (bus_done || bus_timeout)                state_next = RESP;
        else if ((state_reg == REQ) && !i_wb_stall) state_next = WAIT;
      end
      RESP: if (i_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_reg         <= '0;
      wb_cyc_reg      <= 1'b0;
      wb_stb_reg      <= 1'b0;
      wb_we_reg       <= 1'b0;
      wb_adr_reg      <= '0;
      wb_dat_reg      <= '0;
      wb_sel_reg      <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      rsp_rdata_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_cmd_valid) begin
            cnt_reg    <= '0;
            wb_cyc_reg <= 1'b1;
            wb_stb_reg <= 1'b1;
            wb_we_reg  <= i_cmd_write;
            wb_adr_reg <= i_cmd_addr;
            wb_dat_reg <= i_cmd_wdata;
            wb_sel_reg <= i_cmd_sel;
          end
        end
        REQ, WAIT: begin
          if (cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
          if (bus_done || bus_timeout) begin
            wb_cyc_reg      <= 1'b0;
            wb_stb_reg      <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_err_reg     <= bus_timeout || i_wb_err;
            rsp_timeout_reg <= bus_timeout;
            rsp_rdata_reg   <= (bus_done && i_wb_ack && !i_wb_err && !wb_we_reg) ? i_wb_dat : '0;
          end else if (!i_wb_stall) begin
            wb_stb_reg <= 1'b0;
          end
        end
        RESP: begin
          if (i_rsp_ready) rsp_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_ready   = (state_reg == IDLE);
  assign o_wb_cyc      = wb_cyc_reg;
  assign o_wb_stb      = wb_stb_reg;
  assign o_wb_we       = wb_we_reg;
  assign o_wb_adr      = wb_adr_reg;
  assign o_wb_dat      = wb_dat_reg;
  assign o_wb_sel      = wb_sel_reg;
  assign o_rsp_valid   = rsp_valid_reg;
  assign o_rsp_err     = rsp_err_reg;
  assign o_rsp_timeout = rsp_timeout_reg;
  assign o_rsp_rdata   = rsp_rdata_reg;

endmodule

// File: tb/tb_wdgrv_wb_master.sv
// Bench for wdgrv_wb_master: reactive stall/wait slave, response scoreboard queue,
// one task per scenario.
module tb_wdgrv_wb_master;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_ready = 1'b1;
  logic        wb_stall = 1'b0, wb_ack = 1'b0, wb_err = 1'b0;
  logic [31:0] wb_rdat = '0;

  logic        o_cmd_ready, o_rsp_valid, o_rsp_err, o_rsp_timeout;
  logic [31:0] o_rsp_rdata, o_wb_dat;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [7:0]  o_wb_adr;
  logic [3:0]  o_wb_sel;

  wdgrv_wb_master #(
    .ADDRESS_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_WIDTH(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_sel(cmd_sel),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_rsp_timeout(o_rsp_timeout),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_adr(o_wb_adr),
    .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_dat(wb_rdat)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; logic to; } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;

  // slave configuration: kind 0=ack 1=err 2=ack+err 3=never respond
  int          cfg_stall = 0, cfg_wait = 1, cfg_kind = 0;
  bit          cfg_noisy = 0;
  logic [31:0] cfg_rdata = '0;
  logic        force_ack = 1'b0;

  int cyc_cnt = 0, stb_total = 0, cyc_total = 0, adr_changes = 0;
  logic       prev_stb = 1'b0;
  logic [7:0] prev_adr = '0;

  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    if (o_wb_stb) begin
      stb_total++;
      if (prev_stb && o_wb_adr != prev_adr) adr_changes++;
    end
    if (o_wb_cyc) cyc_total++;
    prev_stb = o_wb_stb;
    prev_adr = o_wb_adr;
  end

  int  stall_cnt = 0, wait_cnt = 0;
  bit  pending = 0;
  always @(negedge clk) begin
    wb_stall = 1'b0; wb_ack = force_ack; wb_err = 1'b0; wb_rdat = '0;
    if (!o_wb_cyc) begin
      stall_cnt = 0; wait_cnt = 0; pending = 0;
    end else if (o_wb_stb) begin
      if (stall_cnt < cfg_stall) begin
        stall_cnt++;
        wb_stall = 1'b1;
        if (cfg_noisy) begin wb_ack = 1'b1; wb_rdat = 32'hBAD0_0BAD; end
      end else if (cfg_wait == 0) begin
        if (cfg_kind == 0 || cfg_kind == 2) begin wb_ack = 1'b1; wb_rdat = cfg_rdata; end
        if (cfg_kind == 1 || cfg_kind == 2) wb_err = 1'b1;
      end else begin
        pending = 1; wait_cnt = cfg_wait;
      end
    end else if (pending) begin
      wait_cnt--;
      if (wait_cnt == 0) begin
        pending = 0;
        if (cfg_kind == 0 || cfg_kind == 2) begin wb_ack = 1'b1; wb_rdat = cfg_rdata; end
        if (cfg_kind == 1 || cfg_kind == 2) wb_err = 1'b1;
      end
    end
  end

  // Drive one command; returns at the negedge after the accepting edge.
  task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [3:0] sel, input logic [31:0] erd, input logic eerr,
                       input logic eto, input bit push, output int acc);
    exp_t e;
    int guard = 0;
    while (!o_cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    n_cmp++;
    if (!o_cmd_ready) begin n_bad++; $display("FAIL issue_ready: cmd_ready=%0b, required 1", o_cmd_ready); end
    if (push) begin e.rdata = erd; e.err = eerr; e.to = eto; exp_q.push_back(e); end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_sel = sel;
    @(negedge clk);
    cmd_valid = 1'b0;
    acc = cyc_cnt;
  endtask

  // Wait for a response, pop the scoreboard and compare the response fields.
  task automatic collect(output int rsp_at);
    exp_t e;
    int guard = 0;
    while (!o_rsp_valid && guard < 100) begin @(negedge clk); guard++; end
    rsp_at = cyc_cnt;
    n_cmp++;
    if (!o_rsp_valid || exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL rsp_wait: rsp_valid=%0b queued=%0d, required valid with a queued entry", o_rsp_valid, exp_q.size());
      if (exp_q.size() > 0) e = exp_q.pop_front();
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (o_rsp_rdata !== e.rdata) begin n_bad++; $display("FAIL rsp_rdata: got %08h, required %08h", o_rsp_rdata, e.rdata); end
      n_cmp++;
      if (o_rsp_err !== e.err) begin n_bad++; $display("FAIL rsp_err: got %0b, required %0b", o_rsp_err, e.err); end
      n_cmp++;
      if (o_rsp_timeout !== e.to) begin n_bad++; $display("FAIL rsp_timeout: got %0b, required %0b", o_rsp_timeout, e.to); end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({o_wb_cyc, o_wb_stb, o_wb_we, o_rsp_valid, o_rsp_err, o_rsp_timeout} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: cyc/stb/we/rv/err/to=%06b, required 000000",
               {o_wb_cyc, o_wb_stb, o_wb_we, o_rsp_valid, o_rsp_err, o_rsp_timeout});
    end
    n_cmp++;
    if (o_wb_adr !== 8'h0 || o_wb_dat !== 32'h0 || o_wb_sel !== 4'h0 || o_rsp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_data: adr=%02h dat=%08h sel=%h rdata=%08h, required all 0", o_wb_adr, o_wb_dat, o_wb_sel, o_rsp_rdata);
    end
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: cmd_ready=%0b, required 1", o_cmd_ready); end
    $display("reset: released, cmd_ready=%0b", o_cmd_ready);
  endtask

  task automatic test_write();
    int acc, rat, s0, c0;
    cfg_stall = 0; cfg_wait = 1; cfg_kind = 0; cfg_rdata = 32'h5555_AAAA;
    s0 = stb_total; c0 = cyc_total;
    issue(1'b1, 8'h00, 32'h0000_3FF1, 4'hF, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    n_cmp++;
    if (!(o_wb_cyc && o_wb_stb && o_wb_we) || o_wb_adr !== 8'h00 || o_wb_dat !== 32'h3FF1 || o_wb_sel !== 4'hF) begin
      n_bad++;
      $display("FAIL write_bus: cyc=%0b stb=%0b we=%0b adr=%02h dat=%08h sel=%h, required 1 1 1 00 00003ff1 f",
               o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel);
    end
    collect(rat);
    n_cmp++;
    if (rat - acc != 2) begin n_bad++; $display("FAIL write_latency: rsp %0d cycles after STB, required 2", rat - acc); end
    n_cmp++;
    if (stb_total - s0 != 1 || cyc_total - c0 != 2) begin
      n_bad++; $display("FAIL write_cycles: stb=%0d cyc=%0d, required 1 and 2", stb_total - s0, cyc_total - c0);
    end
    @(negedge clk);
    n_cmp++;
    if (o_cmd_ready !== 1'b1 || cyc_cnt != acc + 3) begin
      n_bad++; $display("FAIL write_roundtrip: cmd_ready=%0b at +%0d, required 1 at +3", o_cmd_ready, cyc_cnt - acc);
    end
    $display("write: adr=00 dat=00003ff1 latency=%0d", rat - acc);
  endtask

  task automatic test_read_stall();
    int acc, rat, s0, c0, a0;
    cfg_stall = 3; cfg_noisy = 1; cfg_wait = 1; cfg_kind = 0; cfg_rdata = 32'hDEAD_BEEF;
    s0 = stb_total; c0 = cyc_total; a0 = adr_changes;
    issue(1'b0, 8'h04, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, acc);
    collect(rat);
    n_cmp++;
    if (stb_total - s0 != 4 || adr_changes != a0) begin
      n_bad++; $display("FAIL read_stall_stb: stb=%0d adr_changes=%0d, required 4 and 0", stb_total - s0, adr_changes - a0);
    end
    n_cmp++;
    if (cyc_total - c0 != 5) begin n_bad++; $display("FAIL read_stall_cyc: cyc=%0d, required 5", cyc_total - c0); end
    cfg_noisy = 0; cfg_stall = 0;
    @(negedge clk);
    $display("read_stall: adr=04 rdata=%08h stb_cycles=%0d", o_rsp_rdata, stb_total - s0);
  endtask

  task automatic test_timeout();
    int acc, rat, s0, c0;
    cfg_kind = 3; rsp_ready = 1'b0;
    s0 = stb_total; c0 = cyc_total;
    issue(1'b0, 8'h04, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1, 1'b1, acc);
    collect(rat);
    n_cmp++;
    if (cyc_total - c0 != 16 || stb_total - s0 != 1) begin
      n_bad++; $display("FAIL timeout_cycles: cyc=%0d stb=%0d, required 16 and 1", cyc_total - c0, stb_total - s0);
    end
    repeat (4) @(negedge clk);
    @(posedge clk); force_ack = 1'b1;
    @(posedge clk); force_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!o_rsp_valid || !o_rsp_err || !o_rsp_timeout || o_rsp_rdata !== 32'h0 || o_wb_cyc) begin
      n_bad++;
      $display("FAIL late_ack: rv=%0b err=%0b to=%0b rdata=%08h cyc=%0b, required 1 1 1 0 0",
               o_rsp_valid, o_rsp_err, o_rsp_timeout, o_rsp_rdata, o_wb_cyc);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    cfg_kind = 0; cfg_wait = 1;
    issue(1'b1, 8'h00, 32'h0000_00A5, 4'h1, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    collect(rat);
    @(negedge clk);
    $display("timeout: cyc_cycles=%0d then write completed", 16);
  endtask

  task automatic test_ack_err();
    int acc, rat, c0;
    cfg_kind = 2; cfg_wait = 1; cfg_rdata = 32'h1234_5678;
    issue(1'b0, 8'h04, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b1, acc);
    collect(rat);
    @(negedge clk);
    $display("ack_err: read adr=04 err=1 rdata=0");
    cfg_kind = 1; cfg_wait = 0;
    c0 = cyc_total;
    issue(1'b1, 8'h00, 32'h0000_0001, 4'hF, 32'h0, 1'b1, 1'b0, 1'b1, acc);
    collect(rat);
    n_cmp++;
    if (cyc_total - c0 != 1) begin n_bad++; $display("FAIL zero_wait_err: cyc=%0d, required 1", cyc_total - c0); end
    @(negedge clk);
    $display("ack_err: zero-wait err write cyc_cycles=%0d", cyc_total - c0);
    cfg_kind = 0; cfg_wait = 1;
  endtask

  task automatic test_backpressure();
    int acc, rat, h;
    exp_t e;
    cfg_kind = 0; cfg_wait = 1; cfg_rdata = 32'hCAFE_F00D; rsp_ready = 1'b0;
    issue(1'b0, 8'h00, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1, acc);
    collect(rat);
    cfg_rdata = 32'h600D_F00D;
    e.rdata = 32'h600D_F00D; e.err = 1'b0; e.to = 1'b0; exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h04; cmd_wdata = '0; cmd_sel = 4'hF;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (!o_rsp_valid || o_cmd_ready || o_rsp_rdata !== 32'hCAFE_F00D || o_rsp_err || o_rsp_timeout) begin
        n_bad++;
        $display("FAIL hold_%0d: rv=%0b rdy=%0b rdata=%08h err=%0b to=%0b, required 1 0 cafef00d 0 0",
                 i, o_rsp_valid, o_cmd_ready, o_rsp_rdata, o_rsp_err, o_rsp_timeout);
      end
      @(negedge clk);
    end
    h = cyc_cnt;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    acc = cyc_cnt;
    n_cmp++;
    if (!o_wb_stb || o_wb_adr !== 8'h04 || o_wb_we || acc != h + 2) begin
      n_bad++;
      $display("FAIL after_handshake: stb=%0b adr=%02h we=%0b at +%0d, required 1 04 0 at +2", o_wb_stb, o_wb_adr, o_wb_we, acc - h);
    end
    collect(rat);
    @(negedge clk);
    $display("backpressure: held 10 cycles, next read rdata=600df00d");
  endtask

  task automatic test_reset_mid();
    int acc;
    cfg_kind = 3;
    issue(1'b0, 8'h04, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    n_cmp++;
    if (!o_wb_cyc || o_wb_stb) begin n_bad++; $display("FAIL mid_wait: cyc=%0b stb=%0b, required 1 0", o_wb_cyc, o_wb_stb); end
    #1 i_rst = 1'b1;
    #1;
    n_cmp++;
    if (o_wb_cyc || o_wb_stb || o_rsp_valid || !o_cmd_ready) begin
      n_bad++;
      $display("FAIL async_reset: cyc=%0b stb=%0b rv=%0b rdy=%0b, required 0 0 0 1", o_wb_cyc, o_wb_stb, o_rsp_valid, o_cmd_ready);
    end
    @(negedge clk);
    i_rst = 1'b0;
    cfg_kind = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (o_rsp_valid || o_wb_cyc || !o_cmd_ready) begin
        n_bad++; $display("FAIL post_reset_%0d: rv=%0b cyc=%0b rdy=%0b, required 0 0 1", i, o_rsp_valid, o_wb_cyc, o_cmd_ready);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left: %0d entries, required 0", exp_q.size()); end
    $display("reset_mid: dropped CYC asynchronously, no stale response");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_timeout();
    test_ack_err();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wdgrv_wb_master.md
Name: wdgrv_wb_master

Overview:
- Single-outstanding Wishbone B4 pipelined bus initiator.
- Turns a simple command/response valid-ready stream into Wishbone cycles aimed at the watchdog register slave (WDCSR at 0x0, WDCNT at 0x4) or any stall-capable Wishbone slave.
- Used by the boot/management controller and the block-level test harness to program and poll the watchdog.
- Provides a bus timeout so a hung slave cannot lock the initiator.

Parameters:
- ADDRESS_WIDTH, 8, width of the command address and o_wb_adr.
- DATA_WIDTH, 32, bus data width; must be a multiple of 8.
- TIMEOUT_WIDTH, 8, width of the timeout counter.
- TIMEOUT_CYCLES, 255, cycles from bus request to forced termination; 0 disables the timeout. Must fit in TIMEOUT_WIDTH.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command accepted when valid & ready
- i_cmd_write  in  1  1 = write, 0 = read
- i_cmd_addr  in  ADDRESS_WIDTH  byte address
- i_cmd_wdata  in  DATA_WIDTH  write data
- i_cmd_sel  in  DATA_WIDTH/8  byte strobes
- o_rsp_valid  out  1  response valid; held until accepted
- i_rsp_ready  in  1  response accepted
- o_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- o_rsp_err  out  1  slave err or timeout
- o_rsp_timeout  out  1  termination was caused by the timeout
- o_wb_cyc  out  1  Wishbone CYC
- o_wb_stb  out  1  Wishbone STB
- o_wb_we  out  1  Wishbone WE
- o_wb_adr  out  ADDRESS_WIDTH  Wishbone ADR
- o_wb_dat  out  DATA_WIDTH  Wishbone DAT_O
- o_wb_sel  out  DATA_WIDTH/8  Wishbone SEL
- i_wb_stall  in  1  Wishbone STALL
- i_wb_ack  in  1  Wishbone ACK
- i_wb_err  in  1  Wishbone ERR
- i_wb_dat  in  DATA_WIDTH  Wishbone DAT_I

Behaviour:
- Reset (async, i_rst=1): state IDLE. o_wb_cyc, o_wb_stb, o_wb_we, o_rsp_valid, o_rsp_err and o_rsp_timeout = 0. o_wb_adr, o_wb_dat, o_wb_sel, o_rsp_rdata and the timeout counter = 0. Reset mid-transfer drops CYC/STB immediately; no response is produced.
- All outputs are registered. o_cmd_ready = (state==IDLE), a registered-state decode.
- IDLE: on i_cmd_valid, capture write/addr/wdata/sel into the wb_* registers, clear the counter and go to REQ. CYC=STB=1 from the next cycle, so command to bus latency is 1 cycle.
- REQ: CYC=STB=1 and the address/data/sel/we registers are stable.
  - i_wb_stall=0: the request is accepted; STB=0 next cycle and go to WAIT.
  - A same-cycle ack/err with stall=0 completes directly (zero-wait slave).
  - i_wb_ack/i_wb_err while stall=1 is ignored.
- WAIT: CYC=1, STB=0. The first cycle with i_wb_ack or i_wb_err completes the transfer.
- Completion: CYC=0 next cycle and go to RESP.
  - o_rsp_rdata = i_wb_dat if read & ack & !err, else 0.
  - o_rsp_err = i_wb_err, o_rsp_timeout = 0.
  - Ack and err together: err wins and rdata = 0.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter increments every cycle in REQ/WAIT.
  - When it equals TIMEOUT_CYCLES-1 with no completion that cycle: CYC=STB=0 next cycle, go to RESP with err=1, timeout=1, rdata=0.
  - Completion in that same cycle beats the timeout.
  - The counter saturates and never wraps.
- RESP: o_rsp_valid=1 with its fields held stable until i_rsp_ready, then IDLE next cycle.
  - No new command is accepted in RESP, so at most one transfer is ever outstanding.
  - Late ack/err arriving outside REQ/WAIT (e.g. after a timeout) are ignored.
- Minimum round trip with a zero-stall, 1-wait slave and rsp_ready tied high: cmd accepted at N, STB N+1, ack N+2, rsp_valid N+3, next cmd_ready N+4.

Decomposition:
- Package wdgrv_wb_master_pkg holds:
  - the state enum {IDLE, REQ, WAIT, RESP};
  - the watchdog register offset constants WDGRV_WDCSR_OFFSET=0x0 and WDGRV_WDCNT_OFFSET=0x4;
  - the WDCSR field LSB/width constants (wden 0, s1wto 2, s2wto 3, wtocnt 4/10).
- Single module, no sub-module: the FSM, the capture registers and the timeout counter are all small.

Test Plan:
- Write 0x0000_3FF1 to 0x0 with sel=0xF, slave with 0 stall and 1 wait -> one STB cycle with adr=0x0, we=1, dat=0x3FF1; rsp_valid with err=0, timeout=0, rdata=0 three cycles after cmd acceptance.
- Read 0x4 with stall held 3 cycles and slave returning 0xDEAD_BEEF -> STB held 4 cycles with a stable address; rsp rdata=0xDEADBEEF, err=0; CYC deasserts the cycle after ack.
- Slave never acks, TIMEOUT_CYCLES=16 -> CYC drops after 16 bus cycles; rsp err=1, timeout=1, rdata=0; a late ack 5 cycles later is ignored and a following command completes normally.
- Slave asserts ack and err together on a read -> err=1, timeout=0, rdata=0.
- rsp_ready held low 10 cycles with cmd_valid high -> rsp fields stable, cmd_ready=0 throughout; the next command is accepted only after the handshake.
- i_rst pulsed while in WAIT -> CYC/STB/rsp_valid go to 0 asynchronously; after release cmd_ready=1 and no stale response appears.
